// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 (CPOL=0, CPHA=0) slave, MSB first, full duplex.
//   CS, SCLK and MOSI are oversampled in the clk domain, so no flop is clocked by SCLK.
//   A byte arrives on MOSI and is handed to local logic with a one-cycle rx_valid strobe.
//   Local logic supplies the reply word through a valid/ready TX holding register.
// Ports:
//   clk, rst              system clock; asynchronous active-high reset
//   CS, SCLK, MOSI        SPI inputs from the master (CS active low, SCLK idle low)
//   MISO                  SPI output to the master
//   tx_data/tx_valid      next reply word offered by local logic
//   tx_ready              holding register is empty and can take a word
//   rx_data/rx_valid      last complete received word, plus its update strobe
//   tx_underrun           strobe: a word was loaded while the holding register was empty (0x00 sent)
//   frame_abort           strobe: CS rose part-way through a word
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CS,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t                   state_r, state_n;
  logic [SYNC_STAGES-1:0]   cs_sync_r, sclk_sync_r, mosi_sync_r;
  logic                     cs_hist_r, sclk_hist_r;
  logic                     cs_s, sclk_s, mosi_s;
  logic                     cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s;
  logic [CNT_W-1:0]         bit_cnt_r;
  logic [DATA_W-2:0]        rx_shift_r;
  logic [DATA_W-1:0]        rx_next_s;
  logic [DATA_W-1:0]        tx_shift_r;
  logic [DATA_W-1:0]        hold_r;
  logic [DATA_W-1:0]        word_s;
  logic                     tx_ready_r, miso_r, rx_valid_r, tx_underrun_r, frame_abort_r;
  logic [DATA_W-1:0]        rx_data_r;
  logic                     load_s, accept_s;

  // Input synchronisers plus one history flop per edge-detected signal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_r   <= '1;
      sclk_sync_r <= '0;
      mosi_sync_r <= '0;
      cs_hist_r   <= 1'b1;
      sclk_hist_r <= 1'b0;
    end else begin
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], CS};
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
      cs_hist_r   <= cs_sync_r[SYNC_STAGES-1];
      sclk_hist_r <= sclk_sync_r[SYNC_STAGES-1];
    end
  end

  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign cs_fall_s   = cs_hist_r & ~cs_s;
  assign cs_rise_s   = ~cs_hist_r & cs_s;
  assign sclk_rise_s = ~sclk_hist_r & sclk_s;
  assign sclk_fall_s = sclk_hist_r & ~sclk_s;

  // Load strobe, reply-word selection and the TX handshake.
  // A boundary load needs CS still low; a CS rise in the same cycle ends the frame instead.
  always_comb begin
    load_s    = 1'b0;
    accept_s  = tx_valid & tx_ready_r;
    word_s    = tx_ready_r ? '0 : hold_r;
    rx_next_s = {rx_shift_r, mosi_s};
    if (cs_rise_s) begin
      load_s = 1'b0;
    end else if (state_r == LOAD) begin
      load_s = 1'b1;
    end else if ((state_r == SHIFT) && sclk_fall_s && (bit_cnt_r == '0)) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) state_n = LOAD;
        else           state_n = IDLE;
      end
      LOAD: begin
        if (cs_rise_s) state_n = IDLE;
        else           state_n = SHIFT;
      end
      SHIFT: begin
        if (cs_rise_s) state_n = IDLE;
        else           state_n = SHIFT;
      end
      default: state_n = IDLE;
    endcase
  end

  // TX holding register: a same-cycle accept wins over the load, so tx_ready stays low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r        <= '0;
      tx_ready_r    <= 1'b1;
      tx_underrun_r <= 1'b0;
    end else begin
      tx_underrun_r <= load_s & tx_ready_r;
      if (accept_s) begin
        hold_r     <= tx_data;
        tx_ready_r <= 1'b0;
      end else if (load_s) begin
        tx_ready_r <= 1'b1;
      end else begin
        tx_ready_r <= tx_ready_r;
      end
    end
  end

  // Shift datapath: RX assembly on SCLK rise, TX shift or word load on SCLK fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_r     <= '0;
      rx_shift_r    <= '0;
      tx_shift_r    <= '0;
      rx_data_r     <= '0;
      miso_r        <= 1'b0;
      rx_valid_r    <= 1'b0;
      frame_abort_r <= 1'b0;
    end else begin
      rx_valid_r    <= 1'b0;
      frame_abort_r <= 1'b0;
      case (state_r)
        IDLE: begin
          miso_r    <= 1'b0;
          bit_cnt_r <= '0;
        end
        LOAD: begin
          if (load_s) begin
            tx_shift_r <= word_s;
            miso_r     <= word_s[DATA_W-1];
          end else begin
            miso_r <= 1'b0;
          end
        end
        SHIFT: begin
          if (cs_rise_s) begin
            // Partial word is dropped; rx_data keeps the last complete word.
            frame_abort_r <= (bit_cnt_r != '0);
            bit_cnt_r     <= '0;
            miso_r        <= 1'b0;
          end else if (sclk_rise_s) begin
            rx_shift_r <= rx_next_s[DATA_W-2:0];
            if (bit_cnt_r == LAST_BIT) begin
              rx_data_r  <= rx_next_s;
              rx_valid_r <= 1'b1;
              bit_cnt_r  <= '0;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end else if (sclk_fall_s) begin
            if (load_s) begin
              tx_shift_r <= word_s;
              miso_r     <= word_s[DATA_W-1];
            end else begin
              tx_shift_r <= tx_shift_r << 1;
              miso_r     <= tx_shift_r[DATA_W-2];
            end
          end else begin
            bit_cnt_r <= bit_cnt_r;
          end
        end
        default: begin
          miso_r    <= 1'b0;
          bit_cnt_r <= '0;
        end
      endcase
    end
  end

  assign MISO        = miso_r;
  assign tx_ready    = tx_ready_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_underrun = tx_underrun_r;
  assign frame_abort = frame_abort_r;

endmodule
